mio_bus_responder: RTL and testbench
====================================

MIO_BUS_RESPONDER -- requirements
Module: mio_bus_responder

Interface
REQ-001 SHALL have parameter RAM_LAT, default 2, meaning data-RAM read wait cycles (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port CPU_MIO  input  1  CPU bus request valid, held until MIO_ready seen.
REQ-005 SHALL have port MemRead  input  1  read request qualifier.
REQ-006 SHALL have port MemWrite  input  1  write request qualifier.
REQ-007 SHALL have port addr_bus  input  32  byte address from CPU.
REQ-008 SHALL have port Data_out  input  32  CPU write data.
REQ-009 SHALL have port ram_data_out  input  32  data RAM read port, valid RAM_LAT cycles after ram_addr is stable.
REQ-010 SHALL have port SW  input  16  switch inputs.
REQ-011 SHALL have port counter_out  input  32  timer count value.
REQ-012 SHALL have port MIO_ready  output  1  one-cycle transfer-complete pulse to the CPU.
REQ-013 SHALL have port Cpu_data4bus  output  32  registered read data to the CPU.
REQ-014 SHALL have port ram_addr  output  10  latched word address, addr_bus[11:2].
REQ-015 SHALL have port ram_data_in  output  32  latched write data to the RAM.
REQ-016 SHALL have port data_ram_we  output  1  RAM write strobe.
REQ-017 SHALL have port GPIOe0000000_we  output  1  display register write strobe.
REQ-018 SHALL have port GPIOf0000000_we  output  1  LED register write strobe.
REQ-019 SHALL have port counter_we  output  1  timer load strobe.
REQ-020 SHALL have port Peripheral_in  output  32  latched write data to the peripherals.

Function
REQ-021 SHALL decode the address latched at accept: 0x0000_0000-0x0000_0FFF is RAM; 0xE000_0000-0xEFFF_FFFF is GPIOe; 0xF000_0000 is GPIOf/SW; 0xF000_0004 is counter; everything else is unmapped.
REQ-022 SHALL implement the FSM states IDLE, WAIT and ACK.
REQ-023 SHALL treat a request as present in IDLE when CPU_MIO=1 and exactly one of MemRead or MemWrite is 1. On that edge it latches addr_bus and Data_out and performs region decode.
REQ-024 SHALL go from IDLE to WAIT, loading the wait counter with RAM_LAT-1, for a RAM read. All other requests go directly from IDLE to ACK.
REQ-025 SHALL decrement the wait counter by one each cycle in WAIT. It goes to ACK on the edge where the counter equals 0, and captures ram_data_out into Cpu_data4bus on that edge.
REQ-026 SHALL, on entry to ACK for a peripheral read, load Cpu_data4bus as follows: {16'h0,SW} for 0xF000_0000, counter_out for 0xF000_0004, and the last value written to GPIOe for the GPIOe region.
REQ-027 SHALL, in ACK, drive MIO_ready=1 for exactly one cycle and then return to IDLE. A request present in the following IDLE cycle is accepted as a new transfer.
REQ-028 SHALL, in ACK for a write, pulse exactly one strobe selected by region for that single cycle; ram_data_in and Peripheral_in equal the latched Data_out.
REQ-029 SHALL complete unmapped accesses with MIO_ready: reads return 32'h0000_0000 and writes raise no strobe.
REQ-030 SHALL ignore CPU_MIO=1 with MemRead=MemWrite=1 or MemRead=MemWrite=0: state stays IDLE, no MIO_ready, no strobe.
REQ-031 SHALL ignore changes on request inputs during WAIT/ACK, since the latched address and data govern the transfer.
REQ-032 SHALL give the latencies as follows: write, peripheral read and unmapped access acknowledge 1 cycle after accept; RAM read acknowledges 1+RAM_LAT cycles after accept.
REQ-033 SHALL hold Cpu_data4bus stable from ACK until the next read acknowledge; writes do not alter it.

Reset
REQ-034 SHALL, on reset=1, immediately force state IDLE and set MIO_ready, all strobes, Cpu_data4bus, ram_addr, ram_data_in, Peripheral_in, the wait counter and the GPIOe shadow to 0.
REQ-035 SHALL, on reset asserted mid-WAIT or mid-ACK, abort the transfer with no MIO_ready and no strobe. The first accept after reset release is a fresh transfer.

Verification
REQ-036 SHALL check: RAM read at 0x0000_0010 with RAM_LAT=2 and ram_data_out=0x1234_5678 -> ram_addr=4; MIO_ready pulses 3 cycles after accept; Cpu_data4bus=0x1234_5678.
REQ-037 SHALL check: write 0xE000_0000 with data 0xCAFE_F00D -> GPIOe0000000_we pulses 1 cycle with Peripheral_in=0xCAFE_F00D; a following read of 0xE000_0000 returns 0xCAFE_F00D.
REQ-038 SHALL check: read 0xF000_0000 with SW=0xA5A5 -> Cpu_data4bus=0x0000_A5A5 with MIO_ready 1 cycle after accept; read 0xF000_0004 with counter_out=7 -> 0x0000_0007.
REQ-039 SHALL check: read 0x8000_0000 -> MIO_ready with data 0; write there -> MIO_ready with all strobes low.
REQ-040 SHALL check: CPU_MIO=1 with MemRead=MemWrite=1 held 5 cycles -> no MIO_ready and state IDLE throughout.
REQ-041 SHALL check: reset pulsed during WAIT of a RAM read -> no MIO_ready and outputs 0. A back-to-back RAM write at 0x0000_0020 then proceeds, with data_ram_we at ram_addr=8.

Source files
------------

// File: rtl/mio_bus_responder.sv
// Memory-mapped I/O responder: accepts one CPU bus request at a time, decodes it to
// data RAM, GPIO and timer regions, and answers with a single-cycle MIO_ready pulse.
module mio_bus_responder #(
   parameter int RAM_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        CPU_MIO,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr_bus,
   input  logic [31:0] Data_out,
   input  logic [31:0] ram_data_out,
   input  logic [15:0] SW,
   input  logic [31:0] counter_out,
   output logic        MIO_ready,
   output logic [31:0] Cpu_data4bus,
   output logic [9:0]  ram_addr,
   output logic [31:0] ram_data_in,
   output logic        data_ram_we,
   output logic        GPIOe0000000_we,
   output logic        GPIOf0000000_we,
   output logic        counter_we,
   output logic [31:0] Peripheral_in,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [31:0] gpioe_shadow;

   logic req;
   logic is_ram;
   logic is_gpioe;
   logic is_gpiof;
   logic is_cnt;

   // Handshake: CPU_MIO is a valid held by the CPU until it sees MIO_ready; a request
   // is only taken in IDLE with exactly one of MemRead/MemWrite, and MIO_ready is a
   // one-cycle completion pulse, so the CPU must drop CPU_MIO on the cycle it sees it.
   always_comb begin
      req      = CPU_MIO & (MemRead ^ MemWrite);
      is_ram   = (addr_bus[31:12] == 20'h0_0000);
      is_gpioe = (addr_bus[31:28] == 4'hE);
      is_gpiof = (addr_bus == 32'hF000_0000);
      is_cnt   = (addr_bus == 32'hF000_0004);
   end

   assign dbg_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         wait_cnt        <= 4'd0;
         gpioe_shadow    <= 32'h0;
         MIO_ready       <= 1'b0;
         Cpu_data4bus    <= 32'h0;
         ram_addr        <= 10'h0;
         ram_data_in     <= 32'h0;
         Peripheral_in   <= 32'h0;
         data_ram_we     <= 1'b0;
         GPIOe0000000_we <= 1'b0;
         GPIOf0000000_we <= 1'b0;
         counter_we      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  ram_addr      <= addr_bus[11:2];
                  ram_data_in   <= Data_out;
                  Peripheral_in <= Data_out;
                  if (MemWrite) begin
                     state           <= ACK;
                     MIO_ready       <= 1'b1;
                     data_ram_we     <= is_ram;
                     GPIOe0000000_we <= is_gpioe;
                     GPIOf0000000_we <= is_gpiof;
                     counter_we      <= is_cnt;
                     if (is_gpioe) gpioe_shadow <= Data_out;
                  end else if (is_ram) begin
                     state    <= WAIT;
                     wait_cnt <= 4'(RAM_LAT - 1);
                  end else begin
                     // Peripheral and unmapped reads answer straight from the decode.
                     state     <= ACK;
                     MIO_ready <= 1'b1;
                     if (is_gpioe)      Cpu_data4bus <= gpioe_shadow;
                     else if (is_gpiof) Cpu_data4bus <= {16'h0, SW};
                     else if (is_cnt)   Cpu_data4bus <= counter_out;
                     else               Cpu_data4bus <= 32'h0;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state        <= ACK;
                  MIO_ready    <= 1'b1;
                  Cpu_data4bus <= ram_data_out;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ACK: begin
               state           <= IDLE;
               MIO_ready       <= 1'b0;
               data_ram_we     <= 1'b0;
               GPIOe0000000_we <= 1'b0;
               GPIOf0000000_we <= 1'b0;
               counter_we      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: directed scenarios plus randomized transfers checked
// against a region-level model of the bus map, a word-array RAM and a GPIOe shadow.
module tb_mio_bus_responder;

   localparam int RAM_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        CPU_MIO, MemRead, MemWrite;
   logic [31:0] addr_bus, Data_out, ram_data_out, counter_out;
   logic [15:0] SW;
   logic        MIO_ready;
   logic [31:0] Cpu_data4bus, ram_data_in, Peripheral_in;
   logic [9:0]  ram_addr;
   logic        data_ram_we, GPIOe0000000_we, GPIOf0000000_we, counter_we;
   logic [1:0]  dbg_state;
   logic [3:0]  stb_w;

   always #5 clk = ~clk;

   mio_bus_responder #(.RAM_LAT(RAM_LAT)) dut (
      .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .MemRead(MemRead), .MemWrite(MemWrite),
      .addr_bus(addr_bus), .Data_out(Data_out), .ram_data_out(ram_data_out), .SW(SW),
      .counter_out(counter_out), .MIO_ready(MIO_ready), .Cpu_data4bus(Cpu_data4bus),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in), .data_ram_we(data_ram_we),
      .GPIOe0000000_we(GPIOe0000000_we), .GPIOf0000000_we(GPIOf0000000_we),
      .counter_we(counter_we), .Peripheral_in(Peripheral_in), .dbg_state(dbg_state)
   );

   assign stb_w = {data_ram_we, GPIOe0000000_we, GPIOf0000000_we, counter_we};

   int tests_run = 0;
   int tests_failed = 0;

   // Reference state
   logic [31:0] exp_mem [1024];
   logic [31:0] gpioe_m;
   logic [31:0] last_rd;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic [3:0]  stb_ack;
      logic [3:0]  stb_other;
      logic [31:0] pin;
      logic [31:0] rin;
      logic [9:0]  raddr;
      logic        mio_after;
   } obs_t;

   function automatic logic [31:0] mem_init(input int i);
      return (i == 4) ? 32'h1234_5678 : (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   // Data RAM: output is only valid once ram_addr has been stable for RAM_LAT cycles.
   initial begin
      logic [31:0] ram_mem [1024];
      logic [9:0]  last_addr;
      int          age;
      for (int i = 0; i < 1024; i++) ram_mem[i] = mem_init(i);
      last_addr    = 'x;
      age          = 0;
      ram_data_out = 32'hBAD0_BAD0;
      forever begin
         @(negedge clk);
         if (data_ram_we === 1'b1) ram_mem[ram_addr] = ram_data_in;
         if (ram_addr !== last_addr) begin
            last_addr = ram_addr;
            age = 1;
         end else if (age < 100) begin
            age++;
         end
         ram_data_out = (age >= RAM_LAT) ? ram_mem[ram_addr] : 32'hBAD0_BAD0;
      end
   end

   // Behavioural bus map: what a transfer must return, how long it takes, which strobe.
   task automatic model_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic [31:0] rd, output logic [3:0] stb);
      bit in_ram, in_e, in_f, in_c;
      in_ram = (a <= 32'h0000_0FFF);
      in_e   = (a >= 32'hE000_0000) && (a <= 32'hEFFF_FFFF);
      in_f   = (a == 32'hF000_0000);
      in_c   = (a == 32'hF000_0004);
      if (wr) begin
         lat = 1;
         stb = {in_ram, in_e, in_f, in_c};
         if (in_e) gpioe_m = d;
         if (in_ram) exp_mem[a[11:2]] = d;
         rd = last_rd;
      end else begin
         lat = in_ram ? 1 + RAM_LAT : 1;
         stb = 4'b0000;
         if (in_ram)    rd = exp_mem[a[11:2]];
         else if (in_e) rd = gpioe_m;
         else if (in_f) rd = {16'h0, SW};
         else if (in_c) rd = counter_out;
         else           rd = 32'h0;
         last_rd = rd;
      end
   endtask

   // Driver: called at a negedge; scrambles request inputs while waiting for MIO_ready.
   task automatic run_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, output obs_t o);
      o = '{lat: -1, rdata: 32'h0, stb_ack: 4'h0, stb_other: 4'h0, pin: 32'h0, rin: 32'h0,
            raddr: 10'h0, mio_after: 1'b0};
      CPU_MIO = 1'b1; MemRead = !wr; MemWrite = wr; addr_bus = a; Data_out = d;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (MIO_ready === 1'b1) begin
            o.lat = c; o.rdata = Cpu_data4bus; o.stb_ack = stb_w;
            o.pin = Peripheral_in; o.rin = ram_data_in; o.raddr = ram_addr;
            break;
         end
         o.stb_other |= stb_w;
         MemRead = 1'($urandom_range(0, 1)); MemWrite = 1'($urandom_range(0, 1));
         addr_bus = $urandom(); Data_out = $urandom();
      end
      CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr_bus = $urandom(); Data_out = $urandom();
      @(negedge clk);
      o.mio_after = MIO_ready;
      o.stb_other |= stb_w;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({MIO_ready, stb_w, dbg_state} !== 7'h0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %h expected 00", {MIO_ready, stb_w, dbg_state});
      end
      tests_run++;
      if ({Cpu_data4bus, ram_data_in, Peripheral_in, ram_addr} !== 106'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected 0", {Cpu_data4bus, ram_data_in, Peripheral_in, ram_addr});
      end
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (MIO_ready !== 1'b0 || dbg_state !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_release_idle: got ready=%b state=%0d expected 0/0", MIO_ready, dbg_state);
      end
   endtask

   task automatic test_ram_read();
      obs_t o; int el; logic [31:0] er; logic [3:0] es;
      model_xfer(1'b0, 32'h0000_0010, 32'h0, el, er, es);
      run_xfer(1'b0, 32'h0000_0010, 32'h0, o);
      tests_run++;
      if (o.raddr !== 10'd4) begin tests_failed++; $display("FAIL ram_read_addr: got %0d expected 4", o.raddr); end
      tests_run++;
      if (o.lat !== 3) begin tests_failed++; $display("FAIL ram_read_latency: got %0d expected 3", o.lat); end
      tests_run++;
      if (o.rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL ram_read_data: got %h expected 12345678", o.rdata); end
      tests_run++;
      if (o.mio_after !== 1'b0 || o.stb_other !== 4'h0) begin
         tests_failed++; $display("FAIL ram_read_pulse: got after=%b stb=%b expected 0/0000", o.mio_after, o.stb_other);
      end
   endtask

   task automatic test_gpioe();
      obs_t o; int el; logic [31:0] er; logic [3:0] es;
      model_xfer(1'b1, 32'hE000_0000, 32'hCAFE_F00D, el, er, es);
      run_xfer(1'b1, 32'hE000_0000, 32'hCAFE_F00D, o);
      tests_run++;
      if (o.lat !== 1 || o.stb_ack !== 4'b0100 || o.stb_other !== 4'h0) begin
         tests_failed++; $display("FAIL gpioe_write_strobe: got lat=%0d stb=%b other=%b expected 1/0100/0000", o.lat, o.stb_ack, o.stb_other);
      end
      tests_run++;
      if (o.pin !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL gpioe_write_data: got %h expected cafef00d", o.pin); end
      tests_run++;
      if (o.rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL write_keeps_rdata: got %h expected 12345678", o.rdata); end
      model_xfer(1'b0, 32'hE000_0000, 32'h0, el, er, es);
      run_xfer(1'b0, 32'hE000_0000, 32'h0, o);
      tests_run++;
      if (o.rdata !== 32'hCAFE_F00D || o.lat !== 1) begin
         tests_failed++; $display("FAIL gpioe_readback: got %h lat=%0d expected cafef00d lat=1", o.rdata, o.lat);
      end
   endtask

   task automatic test_sw_counter();
      obs_t o; int el; logic [31:0] er; logic [3:0] es;
      SW = 16'hA5A5;
      model_xfer(1'b0, 32'hF000_0000, 32'h0, el, er, es);
      run_xfer(1'b0, 32'hF000_0000, 32'h0, o);
      tests_run++;
      if (o.rdata !== 32'h0000_A5A5 || o.lat !== 1) begin
         tests_failed++; $display("FAIL sw_read: got %h lat=%0d expected 0000a5a5 lat=1", o.rdata, o.lat);
      end
      counter_out = 32'd7;
      model_xfer(1'b0, 32'hF000_0004, 32'h0, el, er, es);
      run_xfer(1'b0, 32'hF000_0004, 32'h0, o);
      tests_run++;
      if (o.rdata !== 32'h0000_0007 || o.lat !== 1) begin
         tests_failed++; $display("FAIL counter_read: got %h lat=%0d expected 00000007 lat=1", o.rdata, o.lat);
      end
   endtask

   task automatic test_unmapped();
      obs_t o; int el; logic [31:0] er; logic [3:0] es;
      model_xfer(1'b0, 32'h8000_0000, 32'h0, el, er, es);
      run_xfer(1'b0, 32'h8000_0000, 32'h0, o);
      tests_run++;
      if (o.rdata !== 32'h0 || o.lat !== 1) begin
         tests_failed++; $display("FAIL unmapped_read: got %h lat=%0d expected 0 lat=1", o.rdata, o.lat);
      end
      model_xfer(1'b1, 32'h8000_0000, 32'h1111_2222, el, er, es);
      run_xfer(1'b1, 32'h8000_0000, 32'h1111_2222, o);
      tests_run++;
      if (o.lat !== 1 || o.stb_ack !== 4'h0 || o.stb_other !== 4'h0) begin
         tests_failed++; $display("FAIL unmapped_write: got lat=%0d stb=%b other=%b expected 1/0000/0000", o.lat, o.stb_ack, o.stb_other);
      end
   endtask

   task automatic test_illegal();
      logic bad;
      bad = 1'b0;
      CPU_MIO = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; addr_bus = 32'hE000_0000; Data_out = $urandom();
      for (int i = 0; i < 8; i++) begin
         if (i == 5) begin MemRead = 1'b0; MemWrite = 1'b0; end
         @(negedge clk);
         if (MIO_ready !== 1'b0 || stb_w !== 4'h0 || dbg_state !== 2'd0) bad = 1'b1;
      end
      CPU_MIO = 1'b0;
      tests_run++;
      if (bad !== 1'b0) begin tests_failed++; $display("FAIL illegal_ignored: got activity=%b expected 0", bad); end
   endtask

   task automatic test_reset_mid_wait();
      obs_t o; int el; logic [31:0] er; logic [3:0] es; logic bad; logic [31:0] d;
      CPU_MIO = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr_bus = 32'h0000_0040; Data_out = 32'h0;
      @(negedge clk);
      CPU_MIO = 1'b0; MemRead = 1'b0;
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if ({MIO_ready, stb_w, dbg_state} !== 7'h0 || {Cpu_data4bus, ram_data_in, Peripheral_in, ram_addr} !== 106'h0) begin
         tests_failed++; $display("FAIL reset_mid_wait_outputs: got ctrl=%h data=%h expected 0", {MIO_ready, stb_w, dbg_state}, Cpu_data4bus);
      end
      gpioe_m = 32'h0; last_rd = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (MIO_ready !== 1'b0 || stb_w !== 4'h0) bad = 1'b1;
      end
      tests_run++;
      if (bad !== 1'b0) begin tests_failed++; $display("FAIL reset_abort: got activity=%b expected 0", bad); end
      d = $urandom();
      model_xfer(1'b1, 32'h0000_0020, d, el, er, es);
      run_xfer(1'b1, 32'h0000_0020, d, o);
      tests_run++;
      if (o.stb_ack !== 4'b1000 || o.raddr !== 10'd8 || o.rin !== d || o.lat !== 1) begin
         tests_failed++; $display("FAIL ram_write_after_reset: got stb=%b addr=%0d data=%h lat=%0d expected 1000/8/%h/1", o.stb_ack, o.raddr, o.rin, o.lat, d);
      end
      model_xfer(1'b0, 32'h0000_0020, 32'h0, el, er, es);
      run_xfer(1'b0, 32'h0000_0020, 32'h0, o);
      tests_run++;
      if (o.rdata !== d || o.lat !== 1 + RAM_LAT) begin
         tests_failed++; $display("FAIL ram_readback: got %h lat=%0d expected %h lat=%0d", o.rdata, o.lat, d, 1 + RAM_LAT);
      end
   endtask

   // Back-to-back random transfers across every region, including decode boundaries.
   task automatic test_back_to_back_random();
      obs_t o; int el; logic [31:0] er; logic [3:0] es; logic [31:0] a, d; bit wr; int kind; logic [9:0] w;
      for (int n = 0; n < 120; n++) begin
         kind = $urandom_range(0, 7);
         wr = 1'($urandom_range(0, 1));
         d = $urandom();
         SW = 16'($urandom()); counter_out = $urandom();
         w = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(1016, 1023));
         case (kind)
            0, 1, 2: a = {20'h0, w, 2'($urandom_range(0, 3))};
            3:       a = {4'hE, 28'($urandom())};
            4:       a = ($urandom_range(0, 1) == 1) ? 32'hE000_0000 : 32'hEFFF_FFFF;
            5:       a = 32'hF000_0000;
            6:       a = 32'hF000_0004;
            default: begin
               case ($urandom_range(0, 4))
                  0: a = 32'h0000_1000;
                  1: a = 32'hDFFF_FFFF;
                  2: a = 32'hF000_0001;
                  3: a = 32'hF000_0008;
                  default: a = {4'($urandom_range(1, 13)), 28'($urandom())};
               endcase
            end
         endcase
         model_xfer(wr, a, d, el, er, es);
         run_xfer(wr, a, d, o);
         tests_run++;
         if (o.lat !== el) begin tests_failed++; $display("FAIL rnd_latency a=%h wr=%0d: got %0d expected %0d", a, wr, o.lat, el); end
         tests_run++;
         if (o.rdata !== er) begin tests_failed++; $display("FAIL rnd_rdata a=%h wr=%0d: got %h expected %h", a, wr, o.rdata, er); end
         tests_run++;
         if (o.stb_ack !== es || o.stb_other !== 4'h0) begin
            tests_failed++; $display("FAIL rnd_strobe a=%h wr=%0d: got %b other=%b expected %b other=0000", a, wr, o.stb_ack, o.stb_other, es);
         end
         tests_run++;
         if (o.raddr !== a[11:2] || o.mio_after !== 1'b0) begin
            tests_failed++; $display("FAIL rnd_addr_pulse a=%h: got addr=%h after=%b expected %h/0", a, o.raddr, o.mio_after, a[11:2]);
         end
         if (wr) begin
            tests_run++;
            if (o.pin !== d || o.rin !== d) begin
               tests_failed++; $display("FAIL rnd_wdata a=%h: got pin=%h rin=%h expected %h", a, o.pin, o.rin, d);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      addr_bus = 32'h0; Data_out = 32'h0; SW = 16'h0; counter_out = 32'h0;
      for (int i = 0; i < 1024; i++) exp_mem[i] = mem_init(i);
      gpioe_m = 32'h0; last_rd = 32'h0;
      test_reset();
      test_ram_read();
      test_gpioe();
      test_sw_counter();
      test_unmapped();
      test_illegal();
      test_reset_mid_wait();
      test_back_to_back_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
